// File: rtl/i2s_tx_engine_if.sv
// rtl/i2s_tx_engine_if.sv - sample FIFO read port between the I2S transmit engine and its FIFO
interface i2s_tx_engine_if #(
   parameter int DATA_W = 24
) ();
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_rd_en;

   modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
   modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/i2s_tx_engine.sv
// rtl/i2s_tx_engine.sv - I2S / left-justified / TDM serial transmitter fed from a sample FIFO
// Bit timing comes from an external strobe; one sample is prefetched per slot at the load strobe.
module i2s_tx_engine #(
   parameter int DATA_W = 24,
   parameter int SLOT_W = 32,
   parameter int NUM_CH = 2,
   parameter int MODE   = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            strobe,
   input  logic            enable,
   input  logic            underrun_clr,
   output logic            sdata,
   output logic            ws,
   output logic            busy,
   output logic            underrun,
   i2s_tx_engine_if.master fifo
);

   localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
   localparam int CW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

   localparam logic [BW-1:0] LOAD_POS = (MODE == 0) ? BW'(1) : BW'(0);
   localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_W - 1);
   localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);
   localparam logic [CW-1:0] CH_HALF  = CW'(NUM_CH / 2);

   if ((DATA_W < 8) || (DATA_W > 32) || (MODE < 0) || (MODE > 1) ||
       ((MODE == 0) && (SLOT_W < DATA_W + 1)) ||
       ((MODE == 1) && (SLOT_W < DATA_W)) ||
       (NUM_CH < 2) || (NUM_CH > 8) || ((NUM_CH % 2) != 0)) begin : g_bad_params
      $error("i2s_tx_engine: illegal DATA_W/SLOT_W/NUM_CH/MODE combination");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]     ch_cnt_q, ch_cnt_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              sdata_q, sdata_d;
   logic              ws_q, ws_d;
   logic              underrun_q, underrun_d;
   logic              pend_q, pend_d;
   logic              rd_en;
   logic              und_set;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      ch_cnt_d  = ch_cnt_q;
      hold_d    = hold_q;
      shift_d   = shift_q;
      sdata_d   = sdata_q;
      ws_d      = ws_q;
      pend_d    = 1'b0;
      rd_en     = 1'b0;
      und_set   = 1'b0;

      case (state_q)
         S_IDLE: begin
            bit_cnt_d = '0;
            ch_cnt_d  = '0;
            shift_d   = '0;
            sdata_d   = 1'b0;
            ws_d      = 1'b0;
            if (enable) state_d = S_PRIME;
         end

         // pend_q marks that a pop was issued last cycle and its data is on fifo_data now.
         S_PRIME: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (pend_q) begin
               hold_d  = fifo.fifo_data;
               state_d = S_RUN;
            end else if (!fifo.fifo_empty) begin
               rd_en  = 1'b1;
               pend_d = 1'b1;
            end
         end

         S_RUN: begin
            if (pend_q) hold_d = fifo.fifo_data;
            if (strobe) begin
               ws_d = (ch_cnt_q >= CH_HALF);
               if (bit_cnt_q == LOAD_POS) begin
                  sdata_d = hold_q[DATA_W-1];
                  shift_d = hold_q << 1;
                  if (!fifo.fifo_empty) begin
                     rd_en  = 1'b1;
                     pend_d = 1'b1;
                  end else begin
                     hold_d  = '0;
                     und_set = 1'b1;
                  end
               end else begin
                  sdata_d = shift_q[DATA_W-1];
                  shift_d = shift_q << 1;
               end

               // A stop request only takes effect on the last bit of the frame.
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  ch_cnt_d  = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + 1'b1;
                  if (!enable && (ch_cnt_q == CH_LAST)) state_d = S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      underrun_d = und_set | (underrun_q & ~underrun_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         ch_cnt_q   <= '0;
         hold_q     <= '0;
         shift_q    <= '0;
         sdata_q    <= 1'b0;
         ws_q       <= 1'b0;
         underrun_q <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         ch_cnt_q   <= ch_cnt_d;
         hold_q     <= hold_d;
         shift_q    <= shift_d;
         sdata_q    <= sdata_d;
         ws_q       <= ws_d;
         underrun_q <= underrun_d;
         pend_q     <= pend_d;
      end
   end

   assign fifo.fifo_rd_en = rd_en & rst_n;
   assign sdata           = sdata_q;
   assign ws              = ws_q;
   assign underrun        = underrun_q;
   assign busy            = (state_q != S_IDLE);

endmodule
